booth_divider_seq: RTL and testbench
====================================

// Module: booth_divider_seq
// PURPOSE
//  Sequential signed (two's complement) integer divider; inverse companion of the Booth
//  multiplier in the same arithmetic datapath. Computes quotient and remainder of
//  dividend_in / divisor_in, one quotient bit per clock, via radix-2 restoring division
//  on magnitudes plus a final sign-fix cycle. Start/busy/done handshake for a host FSM.
// PARAMETERS
//  N        5    operand width in bits (N >= 2); quotient and remainder are also N bits
// PORTS
//  clk             in   1   single clock; all logic on rising edge
//  rst             in   1   synchronous, active-high reset
//  start           in   1   request; sampled only in IDLE
//  dividend_in     in   N   signed dividend, captured at the accepting edge
//  divisor_in      in   N   signed divisor, captured at the accepting edge
//  busy            out  1   high while a division is in flight
//  done            out  1   one-cycle pulse: quotient/remainder/flags valid
//  quotient        out  N   signed quotient, truncated toward zero
//  remainder       out  N   signed remainder; sign follows dividend
//  div_by_zero     out  1   divisor was 0 for the last result
//  overflow        out  1   last result was MIN / -1
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE; busy, done, quotient, remainder, div_by_zero,
//    overflow, counter and internal regs all 0. Reset wins over everything, incl. mid-op.
//  - FSM: IDLE -> CALC -> FIX -> IDLE.
//    IDLE: start=1 at edge E0 latches |dividend|, |divisor|, both sign bits, zero check;
//      busy<=1; next state CALC (or FIX directly if divisor==0). start=0: stay; busy=0.
//    CALC: N cycles (counter 0..N-1, width clog2(N)+1). Each cycle: R={R[N-1:0],Q[N-1]},
//      Q<<=1; if R>=|divisor| then R-=|divisor|, Q[0]=1. R is N+1 bits so no carry loss.
//      After counter reaches N-1, next state FIX.
//    FIX: apply signs: quotient negated if signs differ; remainder negated if dividend
//      negative; register outputs, done<=1, busy<=0, state<=IDLE.
//  - Latency: start accepted at edge E0 -> done high in the cycle after edge E0+N+1
//    (N+1 edges later); divide-by-zero -> done after edge E0+1.
//  - done is exactly one cycle; outputs hold their values until the next done.
//  - start ignored while busy=1 (no queuing, no abort). start high in the done cycle
//    (state IDLE) is accepted: back-to-back throughput one op per N+2 cycles.
//  - Operand inputs need be stable only at the accepting edge.
//  - Magnitude of MIN (1<<(N-1)) is held in N unsigned bits (no sign-extension loss).
//  - Divisor 0: quotient = all ones (-1), remainder = dividend, div_by_zero=1, overflow=0.
//  - MIN / -1: quotient = MIN (wraps), remainder = 0, overflow=1, div_by_zero=0.
//  - All other cases: flags 0; dividend == quotient*divisor + remainder, |rem| < |divisor|.
// STRUCTURE
//  - Shared package: state encoding (IDLE/CALC/FIX as 2-bit localparams) shared with the
//    multiplier's host FSM; no other constants.
//  - One natural sub-module: abs_sign_split (N-bit two's-complement -> {sign, magnitude}),
//    instantiated twice at load; negation in FIX stays inline.
//  - Everything else in one clocked always block plus the CALC combinational compare/sub.
// TESTING (bench uses N=5, range -16..15)
//  1. 13 / 4 -> quotient 3, remainder 1, flags 0; done exactly 6 edges after start edge.
//  2. -13 / 4 -> q -3, r -1; 13 / -4 -> q -3, r 1; -13 / -4 -> q 3, r -1.
//  3. 7 / 0 -> q 5'b11111, r 7, div_by_zero=1, done 1 edge after accept; -16 / -1 ->
//     q -16, r 0, overflow=1.
//  4. start held high continuously with new operands each done cycle -> back-to-back
//     results every 7 cycles; start pulses while busy ignored, outputs unchanged.
//  5. rst asserted during CALC (cycle 3) -> next cycle all outputs 0, IDLE; following
//     start 9/2 gives q 4, r 1 normally.
//  6. Exhaustive sweep of all 32x32 operand pairs vs. golden model (C-style / and %).

Source files
------------

// File: rtl/booth_divider_seq_pkg.sv
// Shared state encoding for the divider and the companion multiplier's host FSM.
package booth_divider_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX
  } div_state_t;

endpackage

// File: rtl/booth_divider_seq_if.sv
// Start/busy/done handshake plus operand and result buses of the signed divider.
interface booth_divider_seq_if #(
  parameter int unsigned N = 5
);

  logic         start;
  logic [N-1:0] dividend_in;
  logic [N-1:0] divisor_in;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  modport master (
    output start, dividend_in, divisor_in,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend_in, divisor_in,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/booth_divider_seq_abs_sign_split.sv
// Splits an N-bit two's-complement value into sign and N-bit unsigned magnitude.
module booth_divider_seq_abs_sign_split #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] value,
  output logic         sign_c,
  output logic [N-1:0] mag_c
);

  // MIN maps to 1<<(N-1), which is representable as an unsigned N-bit magnitude
  assign sign_c = value[N-1];
  assign mag_c  = sign_c ? ((~value) + N'(1)) : value;

endmodule

// File: rtl/booth_divider_seq.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per
// clock, followed by a sign-fix cycle.
module booth_divider_seq
  import booth_divider_seq_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic                clk,
  input  logic                rst,
  booth_divider_seq_if.slave  bus
);

  localparam int unsigned    CW      = $clog2(N) + 1;
  localparam logic [N-1:0]   MIN_MAG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]   ONE     = N'(1);

  div_state_t    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  rem_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  dmag;
  logic          a_neg;
  logic          b_neg;
  logic          dz;
  logic          ovf;

  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  quotient_q;
  logic [N-1:0]  remainder_q;
  logic          dbz_q;
  logic          ovf_q;

  logic          a_sign_c;
  logic          b_sign_c;
  logic [N-1:0]  a_mag_c;
  logic [N-1:0]  b_mag_c;
  logic [N:0]    r_sh_c;
  logic          r_ge_c;
  logic [N-1:0]  r_sub_c;

  booth_divider_seq_abs_sign_split #(.N(N)) u_split_a (
    .value  (bus.dividend_in),
    .sign_c (a_sign_c),
    .mag_c  (a_mag_c)
  );

  booth_divider_seq_abs_sign_split #(.N(N)) u_split_b (
    .value  (bus.divisor_in),
    .sign_c (b_sign_c),
    .mag_c  (b_mag_c)
  );

  // Partial remainder stays below |divisor| between steps, so N stored bits suffice;
  // only the shifted trial value needs the extra bit.
  always_comb begin
    r_sh_c  = {rem_q, quo_q[N-1]};
    r_ge_c  = (r_sh_c >= {1'b0, dmag});
    r_sub_c = N'(r_sh_c - {1'b0, dmag});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dmag        <= '0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      dz          <= 1'b0;
      ovf         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            quo_q  <= a_mag_c;
            dmag   <= b_mag_c;
            rem_q  <= '0;
            a_neg  <= a_sign_c;
            b_neg  <= b_sign_c;
            dz     <= (b_mag_c == '0);
            ovf    <= a_sign_c && (a_mag_c == MIN_MAG) && b_sign_c && (b_mag_c == ONE);
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= (b_mag_c == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          rem_q <= r_ge_c ? r_sub_c : r_sh_c[N-1:0];
          quo_q <= {quo_q[N-2:0], r_ge_c};
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) state <= FIX;
        end
        FIX: begin
          // Divide-by-zero skips CALC, so quo_q still holds |dividend|
          if (dz) begin
            quotient_q  <= '1;
            remainder_q <= a_neg ? ((~quo_q) + ONE) : quo_q;
          end else begin
            quotient_q  <= (a_neg ^ b_neg) ? ((~quo_q) + ONE) : quo_q;
            remainder_q <= a_neg ? ((~rem_q) + ONE) : rem_q;
          end
          dbz_q  <= dz;
          ovf_q  <= ovf;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_booth_divider_seq.sv
// Self-checking bench for booth_divider_seq (N=5) against a plain-arithmetic model.
module tb_booth_divider_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  booth_divider_seq_if #(.N(5)) bus ();

  booth_divider_seq #(.N(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // C-style truncating division with the two documented special cases
  function automatic void model(input int a, input int b, output int q, output int r,
                                output int dz, output int ov);
    dz = 0;
    ov = 0;
    if (b == 0) begin
      q  = -1;
      r  = a;
      dz = 1;
    end else if (a == -16 && b == -1) begin
      q  = -16;
      r  = 0;
      ov = 1;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic wait_done(output int edges);
    edges = 0;
    while (bus.done !== 1'b1 && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic check_result(input string t, input int a, input int b);
    int q, r, dz, ov;
    model(a, b, q, r, dz, ov);
    check_eq({t, " quotient"},  int'(bus.quotient),    q & 31);
    check_eq({t, " remainder"}, int'(bus.remainder),   r & 31);
    check_eq({t, " div0"},      int'(bus.div_by_zero), dz);
    check_eq({t, " ovf"},       int'(bus.overflow),    ov);
  endtask

  task automatic check_zero(input string t);
    check_eq({t, " busy"},      int'(bus.busy),        0);
    check_eq({t, " done"},      int'(bus.done),        0);
    check_eq({t, " quotient"},  int'(bus.quotient),    0);
    check_eq({t, " remainder"}, int'(bus.remainder),   0);
    check_eq({t, " div0"},      int'(bus.div_by_zero), 0);
    check_eq({t, " ovf"},       int'(bus.overflow),    0);
  endtask

  task automatic do_op(input int a, input int b);
    int    edges;
    string t;
    t = $sformatf("%0d/%0d", a, b);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.dividend_in = 5'(a);
    bus.divisor_in  = 5'(b);
    @(posedge clk);
    #1;
    bus.start       = 1'b0;
    bus.dividend_in = 5'($urandom);
    bus.divisor_in  = 5'($urandom);
    check_eq({t, " busy"}, int'(bus.busy), 1);
    wait_done(edges);
    check_eq({t, " latency"}, edges, (b == 0) ? 1 : 6);
    check_result(t, a, b);
  endtask

  initial begin
    int ba[4];
    int bb[4];
    int edges, prev, hold_q, hold_r, acc, dones;
    int q, r, dz, ov;

    ba = '{5, -9, -16, 11};
    bb = '{3, 2, -1, -4};

    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.dividend_in = '0;
    bus.divisor_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    do_op(13, 4);
    do_op(-13, 4);
    do_op(13, -4);
    do_op(-13, -4);
    do_op(7, 0);
    do_op(-16, -1);

    // Back-to-back: start held high, new operands presented in each done cycle
    @(negedge clk);
    bus.start       = 1'b1;
    bus.dividend_in = 5'(ba[0]);
    bus.divisor_in  = 5'(bb[0]);
    @(posedge clk);
    #1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_done(edges);
      check_eq($sformatf("b2b%0d latency", k), edges, 6);
      check_result($sformatf("b2b%0d %0d/%0d", k, ba[k], bb[k]), ba[k], bb[k]);
      if (k > 0) check_eq($sformatf("b2b%0d period", k), cyc - prev, 7);
      prev = cyc;
      if (k < 3) begin
        bus.dividend_in = 5'(ba[k+1]);
        bus.divisor_in  = 5'(bb[k+1]);
        @(posedge clk);
        #1;
      end else begin
        bus.start = 1'b0;
      end
    end
    model(ba[3], bb[3], hold_q, hold_r, dz, ov);

    // start pulses while busy are ignored; previous result holds
    @(negedge clk);
    bus.start       = 1'b1;
    bus.dividend_in = 5'(14);
    bus.divisor_in  = 5'(3);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    acc = cyc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start       = 1'b1;
      bus.dividend_in = 5'($urandom);
      bus.divisor_in  = 5'($urandom);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check_eq($sformatf("hold%0d quotient", i),  int'(bus.quotient),  hold_q & 31);
      check_eq($sformatf("hold%0d remainder", i), int'(bus.remainder), hold_r & 31);
      check_eq($sformatf("hold%0d done", i),      int'(bus.done),      0);
    end
    wait_done(edges);
    check_eq("ignore latency", cyc - acc, 6);
    check_result("ignore 14/3", 14, 3);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dones++;
    end
    check_eq("no extra done", dones, 0);

    // Reset during CALC
    @(negedge clk);
    bus.start       = 1'b1;
    bus.dividend_in = 5'(13);
    bus.divisor_in  = 5'(4);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    do_op(9, 2);

    for (int a = -16; a < 16; a++) begin
      for (int b = -16; b < 16; b++) begin
        do_op(a, b);
      end
    end

    for (int i = 0; i < 100; i++) begin
      q = int'($urandom_range(0, 31)) - 16;
      r = int'($urandom_range(0, 31)) - 16;
      do_op(q, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
